// File: rtl/gen_arb4rr.sv
// gen_arb4rr -- four-port round-robin arbiter sharing one req/ack memory device bus.
// Each master sees a full handshake (hold req, receive a one-cycle ack plus registered
// rdata). A device-ack watchdog keeps a hung device from locking the bus.
//
//   state   | meaning
//   S_IDLE  | no transaction in flight; arbitrate among PEND ports
//   S_REQ   | dev_req high, waiting for dev_ack or watchdog expiry
//   S_ACK   | deliver captured data and ack pulse to the granted port
//   S_GAP   | mandatory idle cycle before the next arbitration
//   FE_IDLE | port has no outstanding request
//   FE_PEND | port request accepted, waiting for service
//   FE_DONE | port serviced; waits for req to drop before re-arming
module gen_arb4rr #(
  parameter logic [3:0]  p_mask    = 4'b1111,
  parameter bit          p_dev16   = 1'b1,
  parameter logic [15:0] p_timeout = 16'd0
) (
  input  logic        dev_clk,
  input  logic        dev_rst_n,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_be,
  output logic        dev_wr,
  output logic        dev_req,
  input  logic [31:0] dev_rdata,
  input  logic        dev_ack,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  input  logic        p0_wr,
  input  logic        p0_req,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  input  logic        p1_wr,
  input  logic        p1_req,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  input  logic [31:0] p2_addr,
  input  logic [31:0] p2_wdata,
  input  logic [3:0]  p2_be,
  input  logic        p2_wr,
  input  logic        p2_req,
  output logic        p2_ack,
  output logic [31:0] p2_rdata,
  input  logic [31:0] p3_addr,
  input  logic [31:0] p3_wdata,
  input  logic [3:0]  p3_be,
  input  logic        p3_wr,
  input  logic        p3_req,
  output logic        p3_ack,
  output logic [31:0] p3_rdata,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_GAP} seq_t;
  typedef enum logic [1:0] {FE_IDLE, FE_PEND, FE_DONE} fe_t;

  localparam bit WD_EN = (p_timeout != 16'd0);

  logic [31:0] addr_in  [4];
  logic [31:0] wdata_in [4];
  logic [3:0]  be_in    [4];
  logic [3:0]  wr_in;
  logic [3:0]  req_in;

  assign addr_in[0]  = p0_addr;
  assign addr_in[1]  = p1_addr;
  assign addr_in[2]  = p2_addr;
  assign addr_in[3]  = p3_addr;
  assign wdata_in[0] = p0_wdata;
  assign wdata_in[1] = p1_wdata;
  assign wdata_in[2] = p2_wdata;
  assign wdata_in[3] = p3_wdata;
  assign be_in[0]    = p0_be;
  assign be_in[1]    = p1_be;
  assign be_in[2]    = p2_be;
  assign be_in[3]    = p3_be;
  assign wr_in       = {p3_wr, p2_wr, p1_wr, p0_wr};
  assign req_in      = {p3_req, p2_req, p1_req, p0_req};

  fe_t         fe_q [4];
  fe_t         fe_d [4];
  seq_t        state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;
  logic        req_q, req_d;
  logic [31:0] cap_q, cap_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
  logic [3:0]  ack_q, ack_d;
  logic [31:0] rdata_q [4];
  logic [31:0] rdata_d [4];

  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        wd_expired;
  logic [31:0] cap_fmt;

  assign wd_expired = WD_EN && (wd_cnt_q == 16'd0);
  assign cap_fmt    = p_dev16 ? {cap_q[15:0], cap_q[15:0]} : cap_q;

  // Per-port front end: a req is accepted once, then must drop before it can re-arm
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      fe_d[n] = fe_q[n];
      case (fe_q[n])
        FE_IDLE: if (req_in[n] && p_mask[n]) fe_d[n] = FE_PEND;
        FE_PEND: if (ack_q[n]) fe_d[n] = FE_DONE;
        FE_DONE: if (!req_in[n]) fe_d[n] = FE_IDLE;
        default: fe_d[n] = FE_IDLE;
      endcase
    end
  end

  // Round-robin pick: first PEND port starting just after the last grant
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = last_q;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!pick_vld && (fe_q[cand] == FE_PEND)) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Sequencer next state: latch, wait for device/watchdog, deliver, gap
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    req_d    = req_q;
    cap_d    = cap_q;
    wd_cnt_d = wd_cnt_q;
    ack_d    = 4'b0000;
    err_d    = err_q;
    for (int n = 0; n < 4; n++) rdata_d[n] = rdata_q[n];
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d  = pick_idx;
          last_d   = pick_idx;
          addr_d   = addr_in[pick_idx];
          wdata_d  = wdata_in[pick_idx];
          be_d     = be_in[pick_idx];
          wr_d     = wr_in[pick_idx];
          req_d    = 1'b1;
          wd_cnt_d = p_timeout - 16'd1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        // a device ack in the expiry cycle takes precedence over the timeout
        if (dev_ack) begin
          cap_d   = dev_rdata;
          req_d   = 1'b0;
          state_d = S_ACK;
        end else if (wd_expired) begin
          cap_d   = 32'hFFFF_FFFF;
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_ACK;
        end else begin
          wd_cnt_d = wd_cnt_q - 16'd1;
        end
      end
      S_ACK: begin
        rdata_d[grant_q] = cap_fmt;
        ack_d[grant_q]   = 1'b1;
        state_d          = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State registers; reset leaves port 0 as the first in line
  always_ff @(posedge dev_clk or negedge dev_rst_n) begin
    if (!dev_rst_n) begin
      for (int n = 0; n < 4; n++) begin
        fe_q[n]    <= FE_IDLE;
        rdata_q[n] <= 32'd0;
      end
      state_q  <= S_IDLE;
      last_q   <= 2'd3;
      grant_q  <= 2'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      wr_q     <= 1'b0;
      req_q    <= 1'b0;
      cap_q    <= 32'd0;
      wd_cnt_q <= 16'd0;
      err_q    <= 1'b0;
      ack_q    <= 4'd0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        fe_q[n]    <= fe_d[n];
        rdata_q[n] <= rdata_d[n];
      end
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      req_q    <= req_d;
      cap_q    <= cap_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  assign dev_addr    = addr_q;
  assign dev_wdata   = wdata_q;
  assign dev_be      = be_q;
  assign dev_wr      = wr_q;
  assign dev_req     = req_q;
  assign grant       = grant_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = err_q;
  assign p0_ack      = ack_q[0];
  assign p1_ack      = ack_q[1];
  assign p2_ack      = ack_q[2];
  assign p3_ack      = ack_q[3];
  assign p0_rdata    = rdata_q[0];
  assign p1_rdata    = rdata_q[1];
  assign p2_rdata    = rdata_q[2];
  assign p3_rdata    = rdata_q[3];

endmodule

// File: tb/tb_gen_arb4rr.sv
// Bench for gen_arb4rr: instance A (all ports, 16-bit device, 16-cycle watchdog)
// and instance B (port 1 masked, 32-bit device, watchdog off).
module tb_gen_arb4rr;

  logic dev_clk = 1'b0;
  always #5 dev_clk = ~dev_clk;
  logic dev_rst_n;

  // instance A
  logic [31:0] a_dev_addr, a_dev_wdata, a_dev_rdata;
  logic [3:0]  a_dev_be;
  logic        a_dev_wr, a_dev_req, a_dev_ack;
  logic [31:0] a_addr [4];
  logic [31:0] a_wdata [4];
  logic [31:0] a_rdata [4];
  logic [3:0]  a_be [4];
  logic        a_wr [4];
  logic        a_req [4];
  logic        a_ack [4];
  logic [1:0]  a_grant;
  logic        a_busy, a_terr, a_err_clr;

  // instance B
  logic [31:0] b_dev_addr, b_dev_wdata, b_dev_rdata;
  logic [3:0]  b_dev_be;
  logic        b_dev_wr, b_dev_req, b_dev_ack;
  logic [31:0] b_addr [4];
  logic [31:0] b_wdata [4];
  logic [31:0] b_rdata [4];
  logic [3:0]  b_be [4];
  logic        b_wr [4];
  logic        b_req [4];
  logic        b_ack [4];
  logic [1:0]  b_grant;
  logic        b_busy, b_terr, b_err_clr;

  gen_arb4rr #(.p_mask(4'b1111), .p_dev16(1'b1), .p_timeout(16'd16)) u_a (
    .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
    .dev_addr(a_dev_addr), .dev_wdata(a_dev_wdata), .dev_be(a_dev_be), .dev_wr(a_dev_wr),
    .dev_req(a_dev_req), .dev_rdata(a_dev_rdata), .dev_ack(a_dev_ack),
    .p0_addr(a_addr[0]), .p0_wdata(a_wdata[0]), .p0_be(a_be[0]), .p0_wr(a_wr[0]),
    .p0_req(a_req[0]), .p0_ack(a_ack[0]), .p0_rdata(a_rdata[0]),
    .p1_addr(a_addr[1]), .p1_wdata(a_wdata[1]), .p1_be(a_be[1]), .p1_wr(a_wr[1]),
    .p1_req(a_req[1]), .p1_ack(a_ack[1]), .p1_rdata(a_rdata[1]),
    .p2_addr(a_addr[2]), .p2_wdata(a_wdata[2]), .p2_be(a_be[2]), .p2_wr(a_wr[2]),
    .p2_req(a_req[2]), .p2_ack(a_ack[2]), .p2_rdata(a_rdata[2]),
    .p3_addr(a_addr[3]), .p3_wdata(a_wdata[3]), .p3_be(a_be[3]), .p3_wr(a_wr[3]),
    .p3_req(a_req[3]), .p3_ack(a_ack[3]), .p3_rdata(a_rdata[3]),
    .grant(a_grant), .busy(a_busy), .timeout_err(a_terr), .err_clr(a_err_clr)
  );

  gen_arb4rr #(.p_mask(4'b1101), .p_dev16(1'b0), .p_timeout(16'd0)) u_b (
    .dev_clk(dev_clk), .dev_rst_n(dev_rst_n),
    .dev_addr(b_dev_addr), .dev_wdata(b_dev_wdata), .dev_be(b_dev_be), .dev_wr(b_dev_wr),
    .dev_req(b_dev_req), .dev_rdata(b_dev_rdata), .dev_ack(b_dev_ack),
    .p0_addr(b_addr[0]), .p0_wdata(b_wdata[0]), .p0_be(b_be[0]), .p0_wr(b_wr[0]),
    .p0_req(b_req[0]), .p0_ack(b_ack[0]), .p0_rdata(b_rdata[0]),
    .p1_addr(b_addr[1]), .p1_wdata(b_wdata[1]), .p1_be(b_be[1]), .p1_wr(b_wr[1]),
    .p1_req(b_req[1]), .p1_ack(b_ack[1]), .p1_rdata(b_rdata[1]),
    .p2_addr(b_addr[2]), .p2_wdata(b_wdata[2]), .p2_be(b_be[2]), .p2_wr(b_wr[2]),
    .p2_req(b_req[2]), .p2_ack(b_ack[2]), .p2_rdata(b_rdata[2]),
    .p3_addr(b_addr[3]), .p3_wdata(b_wdata[3]), .p3_be(b_be[3]), .p3_wr(b_wr[3]),
    .p3_req(b_req[3]), .p3_ack(b_ack[3]), .p3_rdata(b_rdata[3]),
    .grant(b_grant), .busy(b_busy), .timeout_err(b_terr), .err_clr(b_err_clr)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] last_m;
  int         ack_cnt_a [4];

  initial for (int i = 0; i < 4; i++) ack_cnt_a[i] = 0;

  // passive ack counter for instance A
  always @(posedge dev_clk) begin
    for (int i = 0; i < 4; i++) if (a_ack[i] === 1'b1) ack_cnt_a[i] = ack_cnt_a[i] + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed still running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dev_clk);
    #1;
  endtask

  function automatic logic [3:0] ackv_a();
    return {a_ack[3], a_ack[2], a_ack[1], a_ack[0]};
  endfunction

  function automatic logic [3:0] ackv_b();
    return {b_ack[3], b_ack[2], b_ack[1], b_ack[0]};
  endfunction

  task automatic wait_req_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (a_dev_req === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_req_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (b_dev_req === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    dev_rst_n   = 1'b0;
    a_dev_ack   = 1'b0;
    a_dev_rdata = 32'd0;
    a_err_clr   = 1'b0;
    b_dev_ack   = 1'b0;
    b_dev_rdata = 32'd0;
    b_err_clr   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_addr[i] = 32'd0; a_wdata[i] = 32'd0; a_be[i] = 4'd0; a_wr[i] = 1'b0; a_req[i] = 1'b0;
      b_addr[i] = 32'd0; b_wdata[i] = 32'd0; b_be[i] = 4'd0; b_wr[i] = 1'b0; b_req[i] = 1'b0;
    end
    tick();
    tick();
    chk("rst/dev_req", {31'd0, a_dev_req}, 32'd0);
    chk("rst/busy", {31'd0, a_busy}, 32'd0);
    chk("rst/grant", {30'd0, a_grant}, 32'd0);
    chk("rst/terr", {31'd0, a_terr}, 32'd0);
    chk("rst/acks", {28'd0, ackv_a()}, 32'd0);
    chk("rst/dev_addr", a_dev_addr, 32'd0);
    chk("rst/p0_rdata", a_rdata[0], 32'd0);
    dev_rst_n = 1'b1;
    last_m = 2'd3;
    tick();
  endtask

  // one complete transaction on instance A for port g; device acks lat cycles after dev_req
  task automatic txn_a(input int g, input int lat, input logic [31:0] rd, input bit drop,
                       input string tag);
    bit ok;
    wait_req_a(ok);
    chk({tag, "/dev_req_seen"}, {31'd0, ok}, 32'd1);
    if (!ok) return;
    chk({tag, "/grant"}, {30'd0, a_grant}, 32'(g));
    chk({tag, "/dev_addr"}, a_dev_addr, a_addr[g]);
    chk({tag, "/dev_wdata"}, a_dev_wdata, a_wdata[g]);
    chk({tag, "/dev_be"}, {28'd0, a_dev_be}, {28'd0, a_be[g]});
    chk({tag, "/dev_wr"}, {31'd0, a_dev_wr}, {31'd0, a_wr[g]});
    for (int i = 0; i < lat; i++) tick();
    a_dev_ack   = 1'b1;
    a_dev_rdata = rd;
    tick();
    a_dev_ack   = 1'b0;
    a_dev_rdata = $urandom();
    chk({tag, "/req_drop"}, {31'd0, a_dev_req}, 32'd0);
    chk({tag, "/ack_t1"}, {28'd0, ackv_a()}, 32'd0);
    tick();
    chk({tag, "/ack_t2"}, {28'd0, ackv_a()}, 32'd1 << g);
    chk({tag, "/rdata"}, a_rdata[g], {rd[15:0], rd[15:0]});
    tick();
    chk({tag, "/ack_t3"}, {28'd0, ackv_a()}, 32'd0);
    if (drop) a_req[g] = 1'b0;
    last_m = 2'(g);
  endtask

  initial begin
    bit          ok;
    bit          seen_a, seen_b;
    int          cnt;
    int          sub;
    int          snap [4];
    int          order [$];
    int          rr_seq [8];
    logic [31:0] rv;

    do_reset();

    // single read, 16-bit device replication
    a_addr[0] = 32'h0000_0100; a_wr[0] = 1'b0; a_be[0] = 4'hF; a_wdata[0] = $urandom();
    a_req[0] = 1'b1;
    txn_a(0, 3, 32'h0000_ABCD, 1'b1, "t1");
    chk("t1/p0_rdata_const", a_rdata[0], 32'hABCD_ABCD);

    // all four requesting after reset: strict rotation starting at port 0
    do_reset();
    rr_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int p = 0; p < 4; p++) begin
      a_addr[p] = $urandom(); a_wdata[p] = $urandom(); a_be[p] = 4'($urandom());
      a_wr[p] = 1'($urandom()); a_req[p] = 1'b1;
      snap[p] = ack_cnt_a[p];
    end
    for (int k = 0; k < 8; k++) begin
      txn_a(rr_seq[k], k % 2, $urandom(), 1'b1, "t2");
      if (k < 4) begin
        tick();
        a_req[rr_seq[k]] = 1'b1;
      end
      if (k == 3)
        for (int p = 0; p < 4; p++) chk("t2/acks_round1", 32'(ack_cnt_a[p] - snap[p]), 32'd1);
    end
    for (int p = 0; p < 4; p++) chk("t2/acks_round2", 32'(ack_cnt_a[p] - snap[p]), 32'd2);

    // req held after ack is not serviced again until it drops
    a_addr[1] = $urandom(); a_wr[1] = 1'b0; a_req[1] = 1'b1;
    txn_a(1, 2, $urandom(), 1'b0, "t3a");
    seen_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_dev_req) seen_a = 1'b1;
      tick();
    end
    chk("t3/no_second_req", {31'd0, seen_a}, 32'd0);
    a_req[1] = 1'b0;
    tick();
    a_req[1] = 1'b1;
    txn_a(1, 1, $urandom(), 1'b1, "t3b");

    // watchdog: write from port 2 never acked
    chk("t4/terr_before", {31'd0, a_terr}, 32'd0);
    a_addr[2] = $urandom(); a_wdata[2] = $urandom(); a_be[2] = 4'h3; a_wr[2] = 1'b1;
    a_req[2] = 1'b1;
    wait_req_a(ok);
    chk("t4/dev_req_seen", {31'd0, ok}, 32'd1);
    chk("t4/grant", {30'd0, a_grant}, 32'd2);
    chk("t4/dev_wr", {31'd0, a_dev_wr}, 32'd1);
    cnt = 0;
    while (a_dev_req && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("t4/req_cycles", 32'(cnt), 32'd16);
    chk("t4/ack_t1", {28'd0, ackv_a()}, 32'd0);
    tick();
    chk("t4/ack_t2", {28'd0, ackv_a()}, 32'd4);
    chk("t4/p2_rdata", a_rdata[2], 32'hFFFF_FFFF);
    chk("t4/terr_set", {31'd0, a_terr}, 32'd1);
    a_req[2] = 1'b0;
    last_m = 2'd2;
    tick();
    a_err_clr = 1'b1;
    chk("t4/terr_hold", {31'd0, a_terr}, 32'd1);
    tick();
    a_err_clr = 1'b0;
    chk("t4/terr_clr", {31'd0, a_terr}, 32'd0);

    // device ack in the very cycle the watchdog expires: ack wins
    a_addr[0] = $urandom(); a_wr[0] = 1'b0; a_req[0] = 1'b1;
    txn_a(0, 15, 32'h5A5A_1234, 1'b1, "awin");
    chk("awin/terr", {31'd0, a_terr}, 32'd0);

    // async reset mid-transaction, then held p3 request is serviced again
    a_addr[3] = $urandom(); a_wdata[3] = $urandom(); a_wr[3] = 1'b0; a_req[3] = 1'b1;
    wait_req_a(ok);
    chk("t5/dev_req_seen", {31'd0, ok}, 32'd1);
    #2;
    dev_rst_n = 1'b0;
    #1;
    chk("t5/req_async", {31'd0, a_dev_req}, 32'd0);
    chk("t5/busy_async", {31'd0, a_busy}, 32'd0);
    chk("t5/acks_async", {28'd0, ackv_a()}, 32'd0);
    tick();
    dev_rst_n = 1'b1;
    last_m = 2'd3;
    txn_a(3, 2, $urandom(), 1'b1, "t5");

    // instance B: port 1 masked, full 32-bit data
    b_addr[0] = 32'h0000_2000; b_addr[1] = $urandom(); b_wr[0] = 1'b0; b_wr[1] = 1'b0;
    b_req[0] = 1'b1; b_req[1] = 1'b1;
    wait_req_b(ok);
    chk("t6/dev_req_seen", {31'd0, ok}, 32'd1);
    chk("t6/grant", {30'd0, b_grant}, 32'd0);
    chk("t6/dev_addr", b_dev_addr, 32'h0000_2000);
    b_dev_ack = 1'b1; b_dev_rdata = 32'h1234_5678;
    tick();
    b_dev_ack = 1'b0;
    tick();
    chk("t6/ack_t2", {28'd0, ackv_b()}, 32'd1);
    chk("t6/p0_rdata", b_rdata[0], 32'h1234_5678);
    tick();
    b_req[0] = 1'b0;
    seen_a = 1'b0; seen_b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (b_dev_req) seen_a = 1'b1;
      if (b_ack[1]) seen_b = 1'b1;
      tick();
    end
    chk("t6/no_req_p1", {31'd0, seen_a}, 32'd0);
    chk("t6/no_ack_p1", {31'd0, seen_b}, 32'd0);
    b_req[1] = 1'b0;

    // random subsets raised together; expected order is rotation distance from last grant
    for (int r = 0; r < 25; r++) begin
      sub = $urandom_range(1, 15);
      for (int p = 0; p < 4; p++) begin
        if (sub[p]) begin
          a_addr[p] = $urandom(); a_wdata[p] = $urandom(); a_be[p] = 4'($urandom());
          a_wr[p] = 1'($urandom()); a_req[p] = 1'b1;
        end
      end
      order = {};
      for (int d = 1; d <= 4; d++) begin
        if (sub[(int'(last_m) + d) % 4]) order.push_back((int'(last_m) + d) % 4);
      end
      foreach (order[k]) begin
        rv = $urandom();
        txn_a(order[k], $urandom_range(0, 5), rv, 1'b1, "rnd");
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
